// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory and feeds IF/ID
// through a small skid buffer. Define FETCH_SKID_EN for a 2-entry buffer (else 1 entry).
`timescale 1ns/1ps

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall_i,
  input  logic        Branch_i,
  input  logic [31:0] BranchAddr_i,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr_o,
  output logic [31:0] PC4_o,
  output logic        Valid_o
);

`ifdef FETCH_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DROP  = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_pc;
  logic [31:0] w_nextPc;
  logic        r_req;
  logic        w_nextReq;
  logic [31:0] r_addr;
  logic [31:0] w_nextAddr;
  logic [1:0]  r_count;
  logic [1:0]  w_nextCount;
  logic [1:0]  w_countAfterPop;
  logic        w_ack;
  logic        w_push;
  logic        w_pop;
  logic        w_room;
  logic [31:0] w_pcPlus4;
  logic [31:0] r_bufInstr [DEPTH];
  logic [31:0] r_bufPc4   [DEPTH];

  // An ack only counts while a request is actually on the bus.
  always_comb begin
    w_ack           = r_req & imem_ack;
    w_pop           = (r_count != 2'd0) & ~Stall_i & ~Branch_i;
    w_push          = (r_state == S_FETCH) & w_ack & ~Branch_i;
    w_countAfterPop = r_count - {1'b0, w_pop};
    w_nextCount     = Branch_i ? 2'd0 : (w_countAfterPop + {1'b0, w_push});
    w_room          = (w_nextCount < DEPTH_C);
    w_pcPlus4       = r_pc + 32'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextPc    = r_pc;
    w_nextReq   = r_req;
    w_nextAddr  = r_addr;
    unique case (r_state)
      S_IDLE: begin
        w_nextState = S_FETCH;
        w_nextReq   = 1'b1;
        w_nextPc    = Branch_i ? BranchAddr_i : r_pc;
        w_nextAddr  = Branch_i ? BranchAddr_i : r_pc;
      end
      S_FETCH: begin
        if (Branch_i) begin
          w_nextPc = BranchAddr_i;
          // A wrong-path request still in flight must be drained before redirecting.
          if (r_req && !imem_ack) begin
            w_nextState = S_DROP;
          end else begin
            w_nextReq  = 1'b1;
            w_nextAddr = BranchAddr_i;
          end
        end else if (w_ack) begin
          w_nextPc = w_pcPlus4;
          if (w_room) begin
            w_nextReq  = 1'b1;
            w_nextAddr = w_pcPlus4;
          end else begin
            w_nextReq   = 1'b0;
            w_nextState = S_WAIT;
          end
        end else if (!r_req && w_room) begin
          w_nextReq  = 1'b1;
          w_nextAddr = r_pc;
        end
      end
      S_DROP: begin
        if (Branch_i) begin
          w_nextPc = BranchAddr_i;
        end
        if (w_ack) begin
          w_nextState = S_FETCH;
          w_nextReq   = 1'b1;
          w_nextAddr  = Branch_i ? BranchAddr_i : r_pc;
        end
      end
      S_WAIT: begin
        if (Branch_i) begin
          w_nextPc    = BranchAddr_i;
          w_nextState = S_FETCH;
          w_nextReq   = 1'b1;
          w_nextAddr  = BranchAddr_i;
        end else if (w_pop) begin
          w_nextState = S_FETCH;
          w_nextReq   = 1'b1;
          w_nextAddr  = r_pc;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_req   <= 1'b0;
      r_addr  <= RESET_PC;
      r_count <= 2'd0;
    end else begin
      r_pc    <= w_nextPc;
      r_req   <= w_nextReq;
      r_addr  <= w_nextAddr;
      r_count <= w_nextCount;
    end
  end

  // Entry 0 is always the head; a pop shifts down and a push lands behind the survivors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_bufInstr[i] <= NOP;
        r_bufPc4[i]   <= 32'd0;
      end
    end else begin
      if (w_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          r_bufInstr[i] <= r_bufInstr[i+1];
          r_bufPc4[i]   <= r_bufPc4[i+1];
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (w_countAfterPop == 2'(i))) begin
          r_bufInstr[i] <= imem_rdata;
          r_bufPc4[i]   <= r_addr + 32'd4;
        end
      end
    end
  end

  always_comb begin
    imem_req  = r_req;
    imem_addr = r_addr;
    Valid_o   = (r_count != 2'd0);
    Instr_o   = Valid_o ? r_bufInstr[0] : NOP;
    PC4_o     = Valid_o ? r_bufPc4[0]   : 32'd0;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that owns the program counter, issues requests to instruction memory, and presents one instruction per cycle to the IF/ID pipeline register. A small skid buffer holds fetched words while the pipeline is stalled. When no fetched word is available, the block presents the NOP encoding instead, which inserts a bubble. Taken branches redirect the PC and discard every fetched or in-flight word on the wrong path.

## Interface
- RESET_PC, 32'h00000000, PC value after reset
- NOP, 32'h00000020 (add r0,r0,r0), word presented when no instruction is valid
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- Stall_i  in  1  hazard unit holds IF/ID; head entry must not be consumed
- Branch_i  in  1  taken branch/jump resolved this cycle
- BranchAddr_i  in  32  redirect target
- imem_req  out  1  request valid (registered)
- imem_addr  out  32  word address of the request (registered)
- imem_ack  in  1  one-cycle pulse; imem_rdata valid in this cycle
- imem_rdata  in  32  fetched instruction
- Instr_o  out  32  head instruction, or NOP when not Valid_o
- PC4_o  out  32  PC+4 of the head instruction; 0 when not valid
- Valid_o  out  1  head entry holds a real instruction

## Operation
- Internal state: PC (next fetch address), a buffer of {instr, pc+4} (depth 2, or 1 without the macro), an occupancy count, and an FSM.
- FSM states:
  - IDLE: only after reset; advances to FETCH on the next edge.
  - FETCH: request issued or eligible for issue.
  - DROP: a wrong-path request is still outstanding.
  - WAIT: buffer full, so no request is issued.
- imem_req is high in FETCH (when issuing) and in DROP. imem_addr is held stable from the rise of imem_req until imem_ack.
- A new request rises only when count < depth. Because a push happens only on ack, an outstanding request can never overflow the buffer.
- Push: imem_ack in FETCH writes {imem_rdata, imem_addr+4} and sets PC <= PC+4.
- Pop: at an edge where count>0, Stall_i=0 and Branch_i=0. Push and pop in the same edge leave count unchanged.
- Branch_i takes priority over everything else:
  - count <= 0 and PC <= BranchAddr_i.
  - Request outstanding with no ack this cycle: go to DROP, keeping the old imem_addr.
  - Ack arrives in the same cycle as the branch: the data is discarded and the FSM goes to FETCH at the target.
- DROP: the ack is discarded. Then go to FETCH with imem_addr = PC.
- Branch_i while in DROP: the PC is updated and the FSM stays in DROP.
- WAIT to FETCH: on the edge where a pop occurs.
- PC and addresses are 32-bit and wrap modulo 2^32. The low two bits of BranchAddr_i are passed through unmodified.

## Timing
- Reset values:
  - state=IDLE, PC=RESET_PC, count=0
  - imem_req=0, imem_addr=RESET_PC
  - Valid_o=0, Instr_o=NOP, PC4_o=0
- First request: imem_req=1 in the cycle after the first edge following rst deassertion.
- Fetch latency: if imem_ack arrives in cycle n, Valid_o=1 with that word from cycle n+1.
- Instr_o, PC4_o and Valid_o are decoded from registered state only. There is no combinational path from imem_rdata, Stall_i or Branch_i.
- Branch timing: if Branch_i is sampled at edge e, Valid_o=0 from e. The first target word is presented no earlier than two cycles after the target request rises.
- Reset asserted mid-request: all state returns to reset values immediately. A later ack of the aborted request is ignored, because imem_req=0.

## Configuration
- FETCH_SKID_EN defined: buffer depth is 2, so back-to-back acks sustain one instruction per cycle even while Stall_i toggles.
- FETCH_SKID_EN undefined: depth is 1 and a request is raised only when count=0. Peak throughput is one instruction every two cycles; all other behaviour is identical.

## Test plan
- Reset with RESET_PC=0x100; memory acks in the same cycle as each request -> addresses 0x100, 0x104, 0x108; PC4_o = 0x104, 0x108, 0x10C. With FETCH_SKID_EN, Valid_o stays high every cycle after the first.
- Stall_i held high for 4 cycles with acks always available -> Instr_o/PC4_o frozen, count=2, state WAIT with imem_req=0. After release, the words pop in order with no loss or duplication.
- Branch_i to 0x200 while a request to 0x10C awaits a 3-cycle ack -> DROP. The 0x10C data is never presented and the next imem_addr is 0x200.
- Branch_i in the same cycle as imem_ack -> the acked word is discarded; next imem_addr is BranchAddr_i and Valid_o=0 for that cycle.
- rst pulsed while imem_req=1 -> outputs return to reset values immediately; a stray ack before the next request leaves count=0.
- PC=0xFFFFFFFC fetch -> the next address wraps to 0x00000000 and PC4_o=0x00000000.
